// File: rtl/cache_pway.sv
// Blocking write-back, write-allocate set-associative cache between the CPU port and the AXI bridge.
// Invalid-way-first victim choice with per-set round-robin fallback, plus a single-beat uncached path.
module cache_pway #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    valid,
    input  logic                    op,
    input  logic                    cachable,
    input  logic [31:0]             addr,
    input  logic [3:0]              wstrb,
    input  logic [31:0]             wdata,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [31:0]             rdata,
    output logic                    rd_req,
    output logic [2:0]              rd_type,
    output logic [31:0]             rd_addr,
    input  logic                    rd_rdy,
    input  logic                    ret_valid,
    input  logic                    ret_last,
    input  logic [31:0]             ret_data,
    output logic                    wr_req,
    output logic [2:0]              wr_type,
    output logic [31:0]             wr_addr,
    output logic [3:0]              wr_wstrb,
    output logic [32*LINE_WORDS-1:0] wr_data,
    input  logic                    wr_rdy
);

    localparam int IDX_W = $clog2(SETS);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int TAG_W = 32 - IDX_W - OFF_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int CNT_W = OFF_W - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS,
        REPLACE,
        REFILL
    } state_e;

    state_e state_q;

    logic              req_op_q;
    logic              req_cach_q;
    logic [31:0]       req_addr_q;
    logic [3:0]        req_wstrb_q;
    logic [31:0]       req_wdata_q;
    logic [WAY_W-1:0]  victim_q;
    logic              victim_valid_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
    logic [31:0]       data_q [WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0][WAYS-1:0]  valid_q;
    logic [SETS-1:0][WAYS-1:0]  dirty_q;
    logic [SETS-1:0][WAY_W-1:0] rr_q;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [CNT_W-1:0]  req_word;

    assign req_idx  = req_addr_q[IDX_W+OFF_W-1:OFF_W];
    assign req_tag  = req_addr_q[31:IDX_W+OFF_W];
    assign req_word = req_addr_q[OFF_W-1:2];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [31:0]       hit_word;
    logic              inv_found;
    logic [WAY_W-1:0]  vict_way;
    logic              vict_valid;
    logic              vict_dirty;

    // Tag compare and victim selection for the buffered request's set.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        vict_way  = rr_q[req_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                vict_way  = WAY_W'(w);
            end
        end
        vict_valid = valid_q[req_idx][vict_way];
        vict_dirty = dirty_q[req_idx][vict_way];
        hit_word   = data_q[hit_way][req_idx][req_word];
    end

    logic              arr_we;
    logic [WAY_W-1:0]  arr_way;
    logic [CNT_W-1:0]  arr_word;
    logic [31:0]       arr_wval;
    logic              tag_we;
    logic              refill_dok;

    always_comb begin
        arr_we   = 1'b0;
        arr_way  = hit_way;
        arr_word = req_word;
        arr_wval = merge_bytes(hit_word, req_wdata_q, req_wstrb_q);
        tag_we   = 1'b0;
        if (state_q == LOOKUP && req_cach_q && hit && req_op_q) begin
            arr_we = 1'b1;
        end else if (state_q == REFILL && ret_valid && req_cach_q) begin
            arr_we   = 1'b1;
            arr_way  = victim_q;
            arr_word = cnt_q;
            arr_wval = (req_op_q && cnt_q == req_word)
                     ? merge_bytes(ret_data, req_wdata_q, req_wstrb_q) : ret_data;
            tag_we   = ret_last;
        end
        refill_dok = req_cach_q ? (req_op_q ? ret_last : (cnt_q == req_word)) : 1'b1;
    end

    // Tag and data arrays carry no reset; the valid bits alone decide whether they are meaningful.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_q[arr_way][req_idx][arr_word] <= arr_wval;
        end
        if (tag_we) begin
            tag_q[victim_q][req_idx] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            req_op_q       <= 1'b0;
            req_cach_q     <= 1'b0;
            req_addr_q     <= '0;
            req_wstrb_q    <= '0;
            req_wdata_q    <= '0;
            victim_q       <= '0;
            victim_valid_q <= 1'b0;
            cnt_q          <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
            rr_q           <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid) begin
                        req_op_q    <= op;
                        req_cach_q  <= cachable;
                        req_addr_q  <= addr;
                        req_wstrb_q <= wstrb;
                        req_wdata_q <= wdata;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_cach_q) begin
                        if (hit) begin
                            if (req_op_q) begin
                                dirty_q[req_idx][hit_way] <= 1'b1;
                            end
                            state_q <= IDLE;
                        end else begin
                            victim_q       <= vict_way;
                            victim_valid_q <= vict_valid;
                            state_q        <= (vict_valid && vict_dirty) ? MISS : REPLACE;
                        end
                    end else begin
                        state_q <= req_op_q ? MISS : REPLACE;
                    end
                end
                MISS: begin
                    if (wr_rdy) begin
                        state_q <= req_cach_q ? REPLACE : IDLE;
                    end
                end
                REPLACE: begin
                    if (rd_rdy) begin
                        state_q <= REFILL;
                    end
                end
                REFILL: begin
                    if (ret_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (ret_last) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                            if (req_cach_q) begin
                                valid_q[req_idx][victim_q] <= 1'b1;
                                dirty_q[req_idx][victim_q] <= req_op_q;
                                // Filling an empty way leaves the round-robin order untouched.
                                if (victim_valid_q) begin
                                    rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(WAYS - 1))
                                                   ? '0 : rr_q[req_idx] + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        addr_ok  = (state_q == IDLE);
        data_ok  = 1'b0;
        rdata    = '0;
        rd_req   = 1'b0;
        rd_type  = '0;
        rd_addr  = '0;
        wr_req   = 1'b0;
        wr_type  = '0;
        wr_addr  = '0;
        wr_wstrb = '0;
        wr_data  = '0;
        case (state_q)
            LOOKUP: begin
                if (req_cach_q && hit) begin
                    data_ok = 1'b1;
                    if (!req_op_q) begin
                        rdata = hit_word;
                    end
                end
            end
            MISS: begin
                wr_req = 1'b1;
                if (req_cach_q) begin
                    wr_type  = 3'b100;
                    wr_addr  = {tag_q[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
                    wr_wstrb = 4'hf;
                    for (int w = 0; w < LINE_WORDS; w++) begin
                        wr_data[32*w +: 32] = data_q[victim_q][req_idx][w];
                    end
                end else begin
                    wr_type  = 3'b010;
                    wr_addr  = req_addr_q;
                    wr_wstrb = req_wstrb_q;
                    wr_data  = {LINE_WORDS{req_wdata_q}};
                    data_ok  = wr_rdy;
                end
            end
            REPLACE: begin
                rd_req  = 1'b1;
                rd_type = req_cach_q ? 3'b100 : 3'b010;
                rd_addr = req_cach_q ? {req_addr_q[31:OFF_W], {OFF_W{1'b0}}} : req_addr_q;
            end
            REFILL: begin
                if (ret_valid && refill_dok) begin
                    data_ok = 1'b1;
                    if (!req_op_q) begin
                        rdata = ret_data;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_pway.sv
// Directed bench for cache_pway at its default geometry (2 ways, 256 sets, 4-word lines).
// Walks cold miss, hits, dirty eviction, round-robin victims, uncached path and mid-refill reset.
module tb_cache_pway;

    logic         clk;
    logic         resetn;
    logic         valid;
    logic         op;
    logic         cachable;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [31:0]  wdata;
    logic         addr_ok;
    logic         data_ok;
    logic [31:0]  rdata;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;

    int checks = 0;
    int errors = 0;

    cache_pway #(.WAYS(2), .SETS(256), .LINE_WORDS(4)) u_dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op), .cachable(cachable),
        .addr(addr), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic o, input logic c, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        valid = 1'b1; op = o; cachable = c; addr = a; wstrb = s; wdata = d;
        @(negedge clk);
        chk("addr_ok", addr_ok, 1);
        tick();
        valid = 1'b0;
    endtask

    task automatic lookup_hit(input logic [31:0] exp_rdata, input logic chk_rdata);
        @(negedge clk);
        chk("hit_data_ok", data_ok, 1);
        if (chk_rdata) chk("hit_rdata", rdata, exp_rdata);
        chk("hit_no_rd_req", rd_req, 0);
        tick();
    endtask

    task automatic lookup_miss();
        @(negedge clk);
        chk("miss_data_ok", data_ok, 0);
        tick();
    endtask

    task automatic rd_hs(input logic [2:0] typ, input logic [31:0] a, input int stall);
        for (int i = 0; i <= stall; i++) begin
            rd_rdy = (i == stall);
            @(negedge clk);
            chk("rd_req", rd_req, 1);
            chk("rd_type", rd_type, typ);
            chk("rd_addr", rd_addr, a);
            chk("rd_no_wr_req", wr_req, 0);
            tick();
        end
        rd_rdy = 1'b0;
    endtask

    task automatic wr_hs(input logic [2:0] typ, input logic [31:0] a, input logic [3:0] s,
                         input logic [127:0] d, input int stall, input logic dok_on_hs);
        for (int i = 0; i <= stall; i++) begin
            wr_rdy = (i == stall);
            @(negedge clk);
            chk("wr_req", wr_req, 1);
            chk("wr_type", wr_type, typ);
            chk("wr_addr", wr_addr, a);
            chk("wr_wstrb", wr_wstrb, s);
            chk("wr_data", wr_data, d);
            chk("wr_data_ok", data_ok, dok_on_hs && (i == stall));
            tick();
        end
        wr_rdy = 1'b0;
    endtask

    task automatic refill4(input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                           input logic [31:0] b3, input int crit, input logic chk_rdata);
        logic [31:0] beats [4];
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        for (int i = 0; i < 4; i++) begin
            ret_valid = 1'b1;
            ret_data  = beats[i];
            ret_last  = (i == 3);
            @(negedge clk);
            chk("refill_data_ok", data_ok, (i == crit));
            if (i == crit && chk_rdata) chk("refill_rdata", rdata, beats[i]);
            tick();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; valid = 1'b0; op = 1'b0; cachable = 1'b0; addr = '0;
        wstrb = '0; wdata = '0; rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
        ret_data = '0; wr_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_addr_ok", addr_ok, 1);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        tick();
        resetn = 1'b1;

        $display("[TB] cold read miss with stalled rd_rdy");
        request(1'b0, 1'b1, 32'h0000_1004, 4'h0, 32'h0);
        lookup_miss();
        rd_hs(3'b100, 32'h0000_1000, 5);
        refill4(32'h11, 32'h22, 32'h33, 32'h44, 1, 1'b1);

        request(1'b0, 1'b1, 32'h0000_1004, 4'h0, 32'h0);
        lookup_hit(32'h22, 1'b1);

        $display("[TB] write hit and read back");
        request(1'b1, 1'b1, 32'h0000_1008, 4'b0011, 32'hAABB_CCDD);
        lookup_hit(32'h0, 1'b0);
        request(1'b0, 1'b1, 32'h0000_1008, 4'h0, 32'h0);
        lookup_hit(32'h0000_CCDD, 1'b1);

        $display("[TB] set 0 conflict fills");
        request(1'b0, 1'b1, 32'h0000_2000, 4'h0, 32'h0);
        lookup_miss();
        rd_hs(3'b100, 32'h0000_2000, 0);
        refill4(32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 1'b1);

        request(1'b0, 1'b1, 32'h0000_3004, 4'h0, 32'h0);
        lookup_miss();
        wr_hs(3'b100, 32'h0000_1000, 4'hf,
              {32'h44, 32'h0000_CCDD, 32'h22, 32'h11}, 2, 1'b0);
        rd_hs(3'b100, 32'h0000_3000, 0);
        refill4(32'hB0, 32'hB1, 32'hB2, 32'hB3, 1, 1'b1);

        request(1'b0, 1'b1, 32'h0000_4008, 4'h0, 32'h0);
        lookup_miss();
        rd_hs(3'b100, 32'h0000_4000, 0);
        refill4(32'hC0, 32'hC1, 32'hC2, 32'hC3, 2, 1'b1);

        request(1'b0, 1'b1, 32'h0000_500C, 4'h0, 32'h0);
        lookup_miss();
        rd_hs(3'b100, 32'h0000_5000, 0);
        refill4(32'hD0, 32'hD1, 32'hD2, 32'hD3, 3, 1'b1);

        request(1'b0, 1'b1, 32'h0000_4008, 4'h0, 32'h0);
        lookup_hit(32'hC2, 1'b1);
        request(1'b0, 1'b1, 32'h0000_500C, 4'h0, 32'h0);
        lookup_hit(32'hD3, 1'b1);

        $display("[TB] write miss allocate with merge");
        request(1'b1, 1'b1, 32'h0000_2004, 4'b1100, 32'h1234_5678);
        lookup_miss();
        rd_hs(3'b100, 32'h0000_2000, 0);
        refill4(32'hE0, 32'hE1, 32'hE2, 32'hE3, 3, 1'b0);
        request(1'b0, 1'b1, 32'h0000_2004, 4'h0, 32'h0);
        lookup_hit(32'h1234_00E1, 1'b1);

        $display("[TB] uncached write and read");
        request(1'b1, 1'b0, 32'hBFAF_0000, 4'b0101, 32'h5);
        lookup_miss();
        wr_hs(3'b010, 32'hBFAF_0000, 4'b0101, {4{32'h5}}, 1, 1'b1);

        request(1'b0, 1'b0, 32'hBFAF_0004, 4'h0, 32'h0);
        lookup_miss();
        rd_hs(3'b010, 32'hBFAF_0004, 0);
        ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h77;
        @(negedge clk);
        chk("unc_rd_data_ok", data_ok, 1);
        chk("unc_rd_rdata", rdata, 32'h77);
        tick();
        ret_valid = 1'b0; ret_last = 1'b0;

        request(1'b0, 1'b1, 32'h0000_500C, 4'h0, 32'h0);
        lookup_hit(32'hD3, 1'b1);
        request(1'b0, 1'b1, 32'h0000_2004, 4'h0, 32'h0);
        lookup_hit(32'h1234_00E1, 1'b1);
        request(1'b0, 1'b1, 32'h0000_2000, 4'h0, 32'h0);
        lookup_hit(32'hE0, 1'b1);

        $display("[TB] reset in the middle of a refill");
        request(1'b0, 1'b1, 32'h0000_6008, 4'h0, 32'h0);
        lookup_miss();
        rd_hs(3'b100, 32'h0000_6000, 0);
        ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'hF0;
        @(negedge clk);
        chk("pre_rst_data_ok", data_ok, 0);
        tick();
        ret_valid = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        chk("mid_rst_addr_ok", addr_ok, 1);
        chk("mid_rst_data_ok", data_ok, 0);
        chk("mid_rst_rd_req", rd_req, 0);
        tick();
        resetn = 1'b1;

        request(1'b0, 1'b1, 32'h0000_2004, 4'h0, 32'h0);
        lookup_miss();
        rd_hs(3'b100, 32'h0000_2000, 0);
        refill4(32'h10, 32'h20, 32'h30, 32'h40, 1, 1'b1);
        request(1'b0, 1'b1, 32'h0000_500C, 4'h0, 32'h0);
        lookup_miss();
        rd_hs(3'b100, 32'h0000_5000, 0);
        refill4(32'h50, 32'h60, 32'h70, 32'h80, 3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
